// File: rtl/heichips25_io_bank.sv
// Purpose : per-pin I/O bank controller between fabric I/Os and bidirectional pad cells.
//           Each pin has a runtime mode (Hi-Z / fabric / force-low / force-high), an input
//           synchroniser and filter, and a sticky rising-edge flag that feeds a maskable interrupt.
// Latency : pad outputs are combinational from fabric_*_i and the mode registers (zero latency);
//           pad_in_i -> fabric_in_o is SYNC_STAGES+1 cycles (SYNC_STAGES+DEBOUNCE_CYCLES+1 with debounce).
//           cfg_rdata_o and irq_o are registered (1 cycle).
// Backpressure: none; config writes always complete in one cycle, out-of-range writes are dropped.
//
// Optional feature: define IO_DEBOUNCE_EN to add a per-pin debounce counter in the filter stage.
//
// Ports:
//   fpga_clk_i / fpga_rst_i       clock, synchronous active-high reset
//   cfg_we_i, cfg_addr_i,         config write {irq_en, mode[1:0]} to pin cfg_addr_i
//   cfg_wdata_i
//   cfg_rdata_o                   registered {rise_flag, irq_en, mode} of pin cfg_addr_i (0 if out of range)
//   irq_clr_i                     write-1-to-clear rise flags
//   irq_o                         registered OR of rise_flag & irq_en
//   fabric_out_i / fabric_oe_i    fabric output data / enable
//   fabric_in_o                   synchronised, filtered pad input
//   pad_in_i / pad_out_o / pad_oe_o   pad p2c / c2p / c2p_en
module heichips25_io_bank #(
    parameter int NUM_IO          = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 15,
    localparam int AW             = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
    input  logic              fpga_clk_i,
    input  logic              fpga_rst_i,
    input  logic              cfg_we_i,
    input  logic [AW-1:0]     cfg_addr_i,
    input  logic [2:0]        cfg_wdata_i,
    output logic [3:0]        cfg_rdata_o,
    input  logic [NUM_IO-1:0] irq_clr_i,
    output logic              irq_o,
    input  logic [NUM_IO-1:0] fabric_out_i,
    input  logic [NUM_IO-1:0] fabric_oe_i,
    output logic [NUM_IO-1:0] fabric_in_o,
    input  logic [NUM_IO-1:0] pad_in_i,
    output logic [NUM_IO-1:0] pad_out_o,
    output logic [NUM_IO-1:0] pad_oe_o
);

    // One extra bit so that an AW-bit address can be compared against NUM_IO itself.
    localparam logic [AW:0] NUM_IO_W = (AW+1)'(NUM_IO);

    logic [1:0]        mode_q [NUM_IO];
    logic [1:0]        mode_d [NUM_IO];
    logic [NUM_IO-1:0] irq_en_q, irq_en_d;
    logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IO-1:0] filt_q, filt_d;
    logic [NUM_IO-1:0] filt_prev_q;
    logic [NUM_IO-1:0] rise_q, rise_d;
    logic [3:0]        rdata_q, rdata_d;
    logic              irq_q, irq_d;
    logic              addr_ok;
    logic [NUM_IO-1:0] sync_out;

    assign addr_ok  = ({1'b0, cfg_addr_i} < NUM_IO_W);
    assign sync_out = sync_q[SYNC_STAGES-1];

    // Config, read-back, flags and interrupt next-state.
    // Read-back uses the current (_q) values, so a same-cycle write to the read pin returns old data.
    always_comb begin
        for (int i = 0; i < NUM_IO; i++) begin
            mode_d[i] = mode_q[i];
        end
        irq_en_d = irq_en_q;
        rdata_d  = '0;
        if (cfg_we_i && addr_ok) begin
            mode_d[cfg_addr_i]   = cfg_wdata_i[1:0];
            irq_en_d[cfg_addr_i] = cfg_wdata_i[2];
        end
        if (addr_ok) begin
            rdata_d = {rise_q[cfg_addr_i], irq_en_q[cfg_addr_i], mode_q[cfg_addr_i]};
        end
        // A new edge overrides a same-cycle clear so no event is lost.
        rise_d = (rise_q & ~irq_clr_i) | (filt_q & ~filt_prev_q);
        irq_d  = |(rise_q & irq_en_q);
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q [NUM_IO];
    logic [CW-1:0] cnt_d [NUM_IO];

    // Counter runs only while the synchronised input disagrees with the filtered value;
    // any agreement restarts it, so short glitches never reach the terminal count.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NUM_IO; i++) begin
            cnt_d[i] = '0;
            if (sync_out[i] != filt_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES)) begin
                    filt_d[i] = sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        for (int i = 0; i < NUM_IO; i++) begin
            if (fpga_rst_i) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    always_comb begin
        filt_d = sync_out;
    end
`endif

    always_ff @(posedge fpga_clk_i) begin
        if (fpga_rst_i) begin
            for (int i = 0; i < NUM_IO; i++) begin
                mode_q[i] <= 2'b00;
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            irq_en_q    <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            rise_q      <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IO; i++) begin
                mode_q[i] <= mode_d[i];
            end
            sync_q[0] <= pad_in_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            irq_en_q    <= irq_en_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            rise_q      <= rise_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    // Output path: pure mux of mode register and fabric signals.
    always_comb begin
        pad_oe_o  = '0;
        pad_out_o = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            case (mode_q[i])
                2'b01: begin
                    pad_oe_o[i]  = fabric_oe_i[i];
                    pad_out_o[i] = fabric_out_i[i];
                end
                2'b10: begin
                    pad_oe_o[i]  = 1'b1;
                end
                2'b11: begin
                    pad_oe_o[i]  = 1'b1;
                    pad_out_o[i] = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign fabric_in_o = filt_q;
    assign cfg_rdata_o = rdata_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_heichips25_io_bank.sv
// Directed bench for heichips25_io_bank with a 24-pin bank, so that address 24 is
// representable on the 5-bit config address and exercises the out-of-range path.
module tb_heichips25_io_bank;

    localparam int N = 24;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 2 + 15 + 1;
`else
    localparam int LAT = 2 + 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [4:0]    cfg_addr;
    logic [2:0]    cfg_wdata;
    logic [3:0]    cfg_rdata;
    logic [N-1:0]  irq_clr;
    logic          irq;
    logic [N-1:0]  fab_out, fab_oe, fab_in, pad_in, pad_out, pad_oe;

    int n_chk  = 0;
    int n_pass = 0;

    heichips25_io_bank #(.NUM_IO(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(15)) dut (
        .fpga_clk_i   (clk),
        .fpga_rst_i   (rst),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_rdata_o  (cfg_rdata),
        .irq_clr_i    (irq_clr),
        .irq_o        (irq),
        .fabric_out_i (fab_out),
        .fabric_oe_i  (fab_oe),
        .fabric_in_o  (fab_in),
        .pad_in_i     (pad_in),
        .pad_out_o    (pad_out),
        .pad_oe_o     (pad_oe)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic         we;
        logic [4:0]   addr;
        logic [2:0]   wdata;
        logic [N-1:0] fo;
        logic [N-1:0] foe;
        logic [N-1:0] exp_oe;
        logic [N-1:0] exp_out;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // {we, addr, wdata, fabric_out, fabric_oe, expected pad_oe, expected pad_out}
        vecs[0] = '{1'b1, 5'd5,  3'b011, 24'h000000, 24'h000000, 24'h000020, 24'h000020};
        vecs[1] = '{1'b1, 5'd3,  3'b001, 24'h000008, 24'h000008, 24'h000028, 24'h000028};
        vecs[2] = '{1'b0, 5'd0,  3'b000, 24'h000000, 24'h000008, 24'h000028, 24'h000020};
        vecs[3] = '{1'b0, 5'd0,  3'b000, 24'h000008, 24'h000008, 24'h000028, 24'h000028};
        vecs[4] = '{1'b1, 5'd3,  3'b000, 24'h000008, 24'h000008, 24'h000020, 24'h000020};
        vecs[5] = '{1'b1, 5'd10, 3'b010, 24'h000000, 24'h000000, 24'h000420, 24'h000020};
        vecs[6] = '{1'b1, 5'd24, 3'b011, 24'hFFFFFF, 24'hFFFFFF, 24'h000420, 24'h000020};
        vecs[7] = '{1'b1, 5'd23, 3'b001, 24'h800008, 24'hFFFFFF, 24'h800420, 24'h800020};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        irq_clr = '0; fab_out = '0; fab_oe = '0; pad_in = '0;
        repeat (3) step();
        chk("rst_pad_oe",  32'(pad_oe), 32'h0);
        chk("rst_pad_out", 32'(pad_out), 32'h0);
        chk("rst_fab_in",  32'(fab_in), 32'h0);
        chk("rst_irq",     32'(irq), 32'h0);
        chk("rst_rdata",   32'(cfg_rdata), 32'h0);
        rst = 1'b0;
        step();

        // Output path and config writes, table driven.
        for (int v = 0; v < 8; v++) begin
            cfg_we = vecs[v].we; cfg_addr = vecs[v].addr; cfg_wdata = vecs[v].wdata;
            fab_out = vecs[v].fo; fab_oe = vecs[v].foe;
            step();
            cfg_we = 1'b0;
            chk($sformatf("vec%0d_oe", v),  32'(pad_oe),  32'(vecs[v].exp_oe));
            chk($sformatf("vec%0d_out", v), 32'(pad_out), 32'(vecs[v].exp_out));
        end
        fab_out = '0; fab_oe = '0;

        // Fabric output passes through with zero latency.
        cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = 3'b001; fab_oe = 24'h000008;
        step();
        cfg_we = 1'b0;
        fab_out = 24'h000008; #1;
        chk("comb_out_hi", 32'(pad_out[3]), 32'h1);
        fab_out = 24'h000000; #1;
        chk("comb_out_lo", 32'(pad_out[3]), 32'h0);
        cfg_we = 1'b1; cfg_wdata = 3'b000;
        step();
        cfg_we = 1'b0;
        chk("pin3_hiz_oe", 32'(pad_oe[3]), 32'h0);
        fab_oe = '0;

        // Config read-back.
        cfg_addr = 5'd5;  step(); chk("rd_pin5",  32'(cfg_rdata), 32'h3);
        cfg_addr = 5'd24; step(); chk("rd_oor",   32'(cfg_rdata), 32'h0);
        cfg_addr = 5'd3;  step(); chk("rd_pin3",  32'(cfg_rdata), 32'h0);
        cfg_addr = 5'd10; step(); chk("rd_pin10", 32'(cfg_rdata), 32'h2);
        cfg_we = 1'b1; cfg_wdata = 3'b011;
        step();
        cfg_we = 1'b0;
        chk("rd_wr_old", 32'(cfg_rdata), 32'h2);
        step();
        chk("rd_wr_new", 32'(cfg_rdata), 32'h3);

        // Input path, rise flag and interrupt on pin 7.
        cfg_we = 1'b1; cfg_addr = 5'd7; cfg_wdata = 3'b100;
        step();
        cfg_we = 1'b0;
        pad_in = 24'h000080;
        for (int c = 1; c <= LAT + 3; c++) begin
            step();
            chk($sformatf("in_lat_c%0d", c), 32'(fab_in), (c >= LAT) ? 32'h80 : 32'h0);
            chk($sformatf("irq_c%0d", c), 32'(irq), (c >= LAT + 2) ? 32'h1 : 32'h0);
        end
        chk("rd_pin7_flag", 32'(cfg_rdata), 32'hC);

        // Clear coinciding with a new edge: the flag must survive.
        pad_in = '0;
        repeat (LAT + 3) step();
        chk("pin7_low", 32'(fab_in[7]), 32'h0);
        chk("flag_sticky", 32'(cfg_rdata), 32'hC);
        pad_in = 24'h000080;
        repeat (LAT) step();
        irq_clr = 24'h000080;
        step();
        irq_clr = '0;
        step();
        chk("set_wins_flag", 32'(cfg_rdata), 32'hC);
        chk("set_wins_irq", 32'(irq), 32'h1);

        // Clear alone.
        irq_clr = 24'h000080;
        step();
        irq_clr = '0;
        chk("clr_irq_lag", 32'(irq), 32'h1);
        step();
        chk("clr_irq_drop", 32'(irq), 32'h0);
        chk("clr_flag", 32'(cfg_rdata), 32'h4);

`ifdef IO_DEBOUNCE_EN
        // Short glitch is filtered out; a long pulse passes after the full latency.
        pad_in = 24'h000001;
        repeat (10) step();
        pad_in[0] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step();
            chk($sformatf("glitch_c%0d", c), 32'(fab_in[0]), 32'h0);
        end
        pad_in[0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            chk($sformatf("deb_c%0d", c), 32'(fab_in[0]), (c >= 18) ? 32'h1 : 32'h0);
        end
        pad_in[0] = 1'b0;
`endif

        // Reset in the middle of operation.
        cfg_addr = 5'd5;
        rst = 1'b1;
        step();
        chk("mid_rst_oe",    32'(pad_oe), 32'h0);
        chk("mid_rst_out",   32'(pad_out), 32'h0);
        chk("mid_rst_in",    32'(fab_in), 32'h0);
        chk("mid_rst_irq",   32'(irq), 32'h0);
        chk("mid_rst_rdata", 32'(cfg_rdata), 32'h0);
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
